sram_tp_be_arb: RTL and testbench
=================================

# sram_tp_be_arb

Two-requester-per-port arbiter and sequencer in front of a two-port, column-enable SRAM (one write port, one read port, one-cycle registered read, zero read data when read is disabled). Round-robin arbitration among two writers and, independently, two readers; registers the winning commands onto the SRAM ports, routes returned read data back to the correct reader, and stalls reads that collide with a same-cycle write so readers always observe write-first data. Sits between pipeline stages and any shared on-chip buffer built from the team's two-port bit-enable SRAM.

## Interface
- ADR_WD, 5, SRAM address width
- DAT_WD, 32, data width
- COL_WD, 8, column (write-enable granule) width; DAT_WD is a multiple of COL_WD; BE_WD = DAT_WD/COL_WD

- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- wrN_req  in  1  writer N (N=0,1) request, held until granted
- wrN_ena  in  BE_WD  writer N column enables
- wrN_adr  in  ADR_WD  writer N address
- wrN_dat  in  DAT_WD  writer N data
- wrN_gnt  out  1  writer N granted this cycle (combinational)
- rdN_req  in  1  reader N request, held until granted
- rdN_adr  in  ADR_WD  reader N address
- rdN_gnt  out  1  reader N granted this cycle (combinational)
- rdN_val  out  1  reader N data valid
- rdN_dat  out  DAT_WD  reader N data, zero when rdN_val=0
- sram_wr_ena  out  BE_WD  to SRAM write column enables
- sram_wr_adr  out  ADR_WD  to SRAM write address
- sram_wr_dat  out  DAT_WD  to SRAM write data
- sram_rd_ena  out  1  to SRAM read enable
- sram_rd_adr  out  ADR_WD  to SRAM read address
- sram_rd_dat  in  DAT_WD  from SRAM read data, valid the cycle after sram_rd_ena

## Operation
- Write arbitration: at most one wrN_gnt per cycle. Only one requesting -> grant it. Both -> grant writer indicated by wr_ptr. After any write grant, wr_ptr points to the other writer. Reset wr_ptr=0.
- Write with wrN_ena all zero is still granted and issued (SRAM no-op); it never causes a read stall.
- Read arbitration: same round-robin with independent rd_ptr (reset 0), applied to eligible readers only.
- Read hazard: reader N ineligible in cycle T if a write is granted in T with nonzero enables and wr adr == rdN_adr. Ineligible reader gets no grant; other eligible reader may be granted; rd_ptr does not advance for a stalled reader.
- Grant = handshake: requester may change payload or drop req the cycle after gnt. Dropping req before gnt is allowed (request withdrawn, no side effect).
- Command stage: granted write registered onto sram_wr_*; cycle with no write grant drives sram_wr_ena=0 (adr/dat hold previous). Granted read registered onto sram_rd_ena=1/sram_rd_adr with 1-bit tag of the winner; otherwise sram_rd_ena=0.
- Return stage: tag delayed one more cycle alongside sram_rd_ena; rdN_val/rdN_dat registered... no: rdN_val = delayed rd_ena & tag==N, rdN_dat = sram_rd_dat when rdN_val else 0 (combinational from SRAM output, no extra register).
- Throughput: one write and one read per cycle sustained; a reader granted in consecutive cycles is legal.

## Timing
- Gnt in cycle T (combinational from req/adr/ptr state).
- SRAM write/read command visible at edge ending T, i.e. during T+1.
- Write data in array after edge ending T+1.
- rdN_val/rdN_dat during T+2 for a read granted in T.
- Write granted in T, same-address read granted in T+1 or later returns new data (SRAM read at T+2 after write at T+1).
- Reset values: all gnt 0 (combinational, forced 0 while rstn=0), sram_wr_ena 0, sram_wr_adr 0, sram_wr_dat 0, sram_rd_ena 0, sram_rd_adr 0, pending tag/valid 0, rdN_val 0, rdN_dat 0, both pointers 0.
- Reset mid-operation: in-flight reads are dropped (no rdN_val after rstn low); writes registered but not yet performed are cancelled (sram_wr_ena=0 next cycle).

## Test plan
- Reset: hold rstn=0 with all req=1 -> all gnt=0, sram_wr_ena=0, sram_rd_ena=0, rdN_val=0 throughout; first cycle after release wr0_gnt=1, rd0_gnt=1.
- Write fairness: wr0_req, wr1_req held high 6 cycles, distinct addresses -> grants alternate 0,1,0,1,0,1; each write lands on sram_wr_* one cycle after its grant.
- Column enables: write 0xAABBCCDD to adr 3, then wr_ena=4'b0010, dat 0x11223344 to adr 3, then read adr 3 -> rdN_dat=0xAABB33DD two cycles after read grant.
- Hazard: wr0 writes 0x12345678 to adr 7 in T while rd0 and rd1 request adr 7 and adr 9 -> rd1 granted T, rd0 granted T+1, rd0_dat=0x12345678 at T+3.
- Read routing: rd0/rd1 both held high alternating addresses 1,2 preloaded with 0x1,0x2 -> rdN_val one-hot, each reader's data matches its address, gaps none, rd_dat=0 when val=0.
- Reset mid-read: rd1 granted in T, rstn=0 in T+1 -> rd1_val never asserted.

Source files
------------

// File: rtl/sram_tp_be_arb.sv
// ---------------------------------------------------------------------------
// sram_tp_be_arb : round-robin 2+2 requester arbiter in front of a two-port
//                  column-enable SRAM, with write-first read hazard stalling.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_tp_be_arb #(
  parameter int ADR_WD = 5,
  parameter int DAT_WD = 32,
  parameter int COL_WD = 8,
  localparam int BE_WD = DAT_WD / COL_WD
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr0_req_i,
  input  logic [BE_WD-1:0]  wr0_ena_i,
  input  logic [ADR_WD-1:0] wr0_adr_i,
  input  logic [DAT_WD-1:0] wr0_dat_i,
  output logic              wr0_gnt_o,
  input  logic              wr1_req_i,
  input  logic [BE_WD-1:0]  wr1_ena_i,
  input  logic [ADR_WD-1:0] wr1_adr_i,
  input  logic [DAT_WD-1:0] wr1_dat_i,
  output logic              wr1_gnt_o,
  input  logic              rd0_req_i,
  input  logic [ADR_WD-1:0] rd0_adr_i,
  output logic              rd0_gnt_o,
  output logic              rd0_val_o,
  output logic [DAT_WD-1:0] rd0_dat_o,
  input  logic              rd1_req_i,
  input  logic [ADR_WD-1:0] rd1_adr_i,
  output logic              rd1_gnt_o,
  output logic              rd1_val_o,
  output logic [DAT_WD-1:0] rd1_dat_o,
  output logic [BE_WD-1:0]  sram_wr_ena_o,
  output logic [ADR_WD-1:0] sram_wr_adr_o,
  output logic [DAT_WD-1:0] sram_wr_dat_o,
  output logic              sram_rd_ena_o,
  output logic [ADR_WD-1:0] sram_rd_adr_o,
  input  logic [DAT_WD-1:0] sram_rd_dat_i
);

  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [BE_WD-1:0]  wr_ena_q;
  logic [ADR_WD-1:0] wr_adr_q;
  logic [DAT_WD-1:0] wr_dat_q;
  logic              rd_ena_q;
  logic [ADR_WD-1:0] rd_adr_q;
  logic              rd_tag_q;
  logic              ret_val_q;
  logic              ret_tag_q;

  logic              w_wr_gnt0, w_wr_gnt1, w_wr_any;
  logic [BE_WD-1:0]  w_wr_ena;
  logic [ADR_WD-1:0] w_wr_adr;
  logic [DAT_WD-1:0] w_wr_dat;
  logic              w_rd0_elig, w_rd1_elig;
  logic              w_rd_gnt0, w_rd_gnt1, w_rd_any;
  logic [ADR_WD-1:0] w_rd_adr;

  assign w_wr_gnt0 = rstn_i & wr0_req_i & (~wr1_req_i | ~wr_ptr_q);
  assign w_wr_gnt1 = rstn_i & wr1_req_i & (~wr0_req_i |  wr_ptr_q);
  assign w_wr_any  = w_wr_gnt0 | w_wr_gnt1;
  assign w_wr_ena  = w_wr_gnt1 ? wr1_ena_i : wr0_ena_i;
  assign w_wr_adr  = w_wr_gnt1 ? wr1_adr_i : wr0_adr_i;
  assign w_wr_dat  = w_wr_gnt1 ? wr1_dat_i : wr0_dat_i;

  // A read colliding with a same-cycle real write waits a cycle so it sees the new data.
  assign w_rd0_elig = rd0_req_i & ~(w_wr_any & (|w_wr_ena) & (w_wr_adr == rd0_adr_i));
  assign w_rd1_elig = rd1_req_i & ~(w_wr_any & (|w_wr_ena) & (w_wr_adr == rd1_adr_i));

  assign w_rd_gnt0 = rstn_i & w_rd0_elig & (~w_rd1_elig | ~rd_ptr_q);
  assign w_rd_gnt1 = rstn_i & w_rd1_elig & (~w_rd0_elig |  rd_ptr_q);
  assign w_rd_any  = w_rd_gnt0 | w_rd_gnt1;
  assign w_rd_adr  = w_rd_gnt1 ? rd1_adr_i : rd0_adr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_wr_gnt0)      wr_ptr_d = 1'b1;
    else if (w_wr_gnt1) wr_ptr_d = 1'b0;
    if (w_rd_gnt0)      rd_ptr_d = 1'b1;
    else if (w_rd_gnt1) rd_ptr_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wr_ena_q  <= '0;
      wr_adr_q  <= '0;
      wr_dat_q  <= '0;
      rd_ena_q  <= 1'b0;
      rd_adr_q  <= '0;
      rd_tag_q  <= 1'b0;
      ret_val_q <= 1'b0;
      ret_tag_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ena_q  <= w_wr_any ? w_wr_ena : '0;
      if (w_wr_any) begin
        wr_adr_q <= w_wr_adr;
        wr_dat_q <= w_wr_dat;
      end
      rd_ena_q  <= w_rd_any;
      if (w_rd_any) begin
        rd_adr_q <= w_rd_adr;
        rd_tag_q <= w_rd_gnt1;
      end
      ret_val_q <= rd_ena_q;
      ret_tag_q <= rd_tag_q;
    end
  end

  assign wr0_gnt_o     = w_wr_gnt0;
  assign wr1_gnt_o     = w_wr_gnt1;
  assign rd0_gnt_o     = w_rd_gnt0;
  assign rd1_gnt_o     = w_rd_gnt1;
  assign sram_wr_ena_o = wr_ena_q;
  assign sram_wr_adr_o = wr_adr_q;
  assign sram_wr_dat_o = wr_dat_q;
  assign sram_rd_ena_o = rd_ena_q;
  assign sram_rd_adr_o = rd_adr_q;
  assign rd0_val_o     = ret_val_q & ~ret_tag_q;
  assign rd1_val_o     = ret_val_q &  ret_tag_q;
  assign rd0_dat_o     = rd0_val_o ? sram_rd_dat_i : '0;
  assign rd1_dat_o     = rd1_val_o ? sram_rd_dat_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_sram_tp_be_arb.sv
// ---------------------------------------------------------------------------
// tb_sram_tp_be_arb : directed + random bench with an SRAM model and a
//                     cycle-level reference of grants and returned data.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_tp_be_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr0_req, wr1_req, rd0_req, rd1_req;
  logic [3:0]  wr0_ena, wr1_ena;
  logic [4:0]  wr0_adr, wr1_adr, rd0_adr, rd1_adr;
  logic [31:0] wr0_dat, wr1_dat;
  logic        wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt, rd0_val, rd1_val;
  logic [31:0] rd0_dat, rd1_dat;
  logic [3:0]  sram_wr_ena;
  logic [4:0]  sram_wr_adr, sram_rd_adr;
  logic [31:0] sram_wr_dat, sram_rd_dat;
  logic        sram_rd_ena;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_tp_be_arb #(.ADR_WD(5), .DAT_WD(32), .COL_WD(8)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .wr0_req_i(wr0_req), .wr0_ena_i(wr0_ena), .wr0_adr_i(wr0_adr), .wr0_dat_i(wr0_dat), .wr0_gnt_o(wr0_gnt),
    .wr1_req_i(wr1_req), .wr1_ena_i(wr1_ena), .wr1_adr_i(wr1_adr), .wr1_dat_i(wr1_dat), .wr1_gnt_o(wr1_gnt),
    .rd0_req_i(rd0_req), .rd0_adr_i(rd0_adr), .rd0_gnt_o(rd0_gnt), .rd0_val_o(rd0_val), .rd0_dat_o(rd0_dat),
    .rd1_req_i(rd1_req), .rd1_adr_i(rd1_adr), .rd1_gnt_o(rd1_gnt), .rd1_val_o(rd1_val), .rd1_dat_o(rd1_dat),
    .sram_wr_ena_o(sram_wr_ena), .sram_wr_adr_o(sram_wr_adr), .sram_wr_dat_o(sram_wr_dat),
    .sram_rd_ena_o(sram_rd_ena), .sram_rd_adr_o(sram_rd_adr), .sram_rd_dat_i(sram_rd_dat)
  );

  // Two-port column-enable SRAM: registered read, zero output when not reading.
  logic [31:0] mem [0:31];
  initial begin
    for (int a = 0; a < 32; a++) mem[a] = '0;
    sram_rd_dat = '0;
  end
  always @(posedge clk) begin
    sram_rd_dat <= sram_rd_ena ? mem[sram_rd_adr] : 32'h0;
    for (int c = 0; c < 4; c++)
      if (sram_wr_ena[c]) mem[sram_wr_adr][c*8 +: 8] <= sram_wr_dat[c*8 +: 8];
  end

  // Reference state: architectural memory contents as seen by granted requests.
  logic [31:0] shadow [0:31];
  initial for (int a = 0; a < 32; a++) shadow[a] = '0;
  logic        m_wpref = 0, m_rpref = 0;
  logic [3:0]  m_wena = 0;
  logic [4:0]  m_wadr = 0, m_radr = 0;
  logic [31:0] m_wdat = 0;
  logic        m_rena = 0;
  logic        m_s1v = 0, m_s1id = 0, m_s2v = 0, m_s2id = 0;
  logic [31:0] m_s1d = 0, m_s2d = 0;
  logic        s_wg0, s_wg1, s_rg0, s_rg1, s_rv0, s_rv1;
  logic [31:0] s_rd0, s_rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic wv0, wv1, wany, wwin, e0, e1, rany, rwin;
    logic [3:0] wena;
    logic [4:0] wadr, radr;
    logic [31:0] wdat;
    @(negedge clk);
    wv0  = rstn && wr0_req;
    wv1  = rstn && wr1_req;
    wany = wv0 || wv1;
    wwin = (wv0 && wv1) ? m_wpref : wv1;
    wena = wwin ? wr1_ena : wr0_ena;
    wadr = wwin ? wr1_adr : wr0_adr;
    wdat = wwin ? wr1_dat : wr0_dat;
    e0   = rstn && rd0_req && !(wany && wena != 0 && wadr == rd0_adr);
    e1   = rstn && rd1_req && !(wany && wena != 0 && wadr == rd1_adr);
    rany = e0 || e1;
    rwin = (e0 && e1) ? m_rpref : e1;
    radr = rwin ? rd1_adr : rd0_adr;

    chk("wr0_gnt", wr0_gnt, wany && !wwin);
    chk("wr1_gnt", wr1_gnt, wany && wwin);
    chk("rd0_gnt", rd0_gnt, rany && !rwin);
    chk("rd1_gnt", rd1_gnt, rany && rwin);
    chk("sram_wr_ena", sram_wr_ena, m_wena);
    chk("sram_wr_adr", sram_wr_adr, m_wadr);
    chk("sram_wr_dat", sram_wr_dat, m_wdat);
    chk("sram_rd_ena", sram_rd_ena, m_rena);
    chk("sram_rd_adr", sram_rd_adr, m_radr);
    chk("rd0_val", rd0_val, m_s2v && !m_s2id);
    chk("rd1_val", rd1_val, m_s2v && m_s2id);
    chk("rd0_dat", rd0_dat, (m_s2v && !m_s2id) ? m_s2d : 32'h0);
    chk("rd1_dat", rd1_dat, (m_s2v && m_s2id) ? m_s2d : 32'h0);

    s_wg0 = wr0_gnt; s_wg1 = wr1_gnt; s_rg0 = rd0_gnt; s_rg1 = rd1_gnt;
    s_rv0 = rd0_val; s_rv1 = rd1_val; s_rd0 = rd0_dat; s_rd1 = rd1_dat;

    if (!rstn) begin
      m_wpref = 0; m_rpref = 0; m_wena = 0; m_wadr = 0; m_wdat = 0;
      m_rena = 0; m_radr = 0; m_s1v = 0; m_s1id = 0; m_s1d = 0;
      m_s2v = 0; m_s2id = 0; m_s2d = 0;
    end else begin
      m_s2v = m_s1v; m_s2id = m_s1id; m_s2d = m_s1d;
      m_s1v = rany;
      m_rena = rany;
      if (rany) begin
        m_s1id  = rwin;
        m_s1d   = shadow[radr];
        m_radr  = radr;
        m_rpref = !rwin;
      end
      m_wena = wany ? wena : 4'h0;
      if (wany) begin
        m_wadr  = wadr;
        m_wdat  = wdat;
        m_wpref = !wwin;
        for (int c = 0; c < 4; c++)
          if (wena[c]) shadow[wadr][c*8 +: 8] = wdat[c*8 +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt;
    rstn = 0;
    wr0_req = 1; wr1_req = 1; rd0_req = 1; rd1_req = 1;
    wr0_ena = 4'hF; wr1_ena = 4'hF; wr0_adr = 0; wr1_adr = 1;
    wr0_dat = $urandom; wr1_dat = $urandom; rd0_adr = 20; rd1_adr = 21;

    // Held in reset with every request high
    repeat (3) begin
      cycle();
      chk("rst_gnts", {s_wg0, s_wg1, s_rg0, s_rg1}, 4'b0000);
    end

    // Release, then writer fairness with distinct addresses
    rstn = 1; nxt = 2;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("fair_wr0", s_wg0, (i % 2 == 0));
      chk("fair_wr1", s_wg1, (i % 2 == 1));
      if (i == 0) chk("rel_rd0", s_rg0, 1'b1);
      if (s_wg0) begin wr0_adr = nxt[4:0]; wr0_dat = $urandom; nxt++; end
      if (s_wg1) begin wr1_adr = nxt[4:0]; wr1_dat = $urandom; nxt++; end
    end
    wr0_req = 0; wr1_req = 0; rd0_req = 0; rd1_req = 0;
    repeat (3) cycle();

    // Column enables
    wr0_req = 1; wr0_adr = 3; wr0_ena = 4'hF; wr0_dat = 32'hAABBCCDD;
    cycle();
    wr0_ena = 4'b0010; wr0_dat = 32'h11223344;
    cycle();
    wr0_req = 0; rd0_req = 1; rd0_adr = 3;
    cycle();
    chk("col_rd_gnt", s_rg0, 1'b1);
    rd0_req = 0;
    cycle();
    cycle();
    chk("col_val", s_rv0, 1'b1);
    chk("col_dat", s_rd0, 32'hAABB33DD);

    // Read stalled behind same-address write
    wr0_req = 1; wr0_adr = 7; wr0_ena = 4'hF; wr0_dat = 32'h12345678;
    rd0_req = 1; rd0_adr = 7; rd1_req = 1; rd1_adr = 9;
    cycle();
    chk("haz_rd1_gnt", s_rg1, 1'b1);
    chk("haz_rd0_stall", s_rg0, 1'b0);
    wr0_req = 0; rd1_req = 0;
    cycle();
    chk("haz_rd0_gnt", s_rg0, 1'b1);
    rd0_req = 0;
    cycle();
    cycle();
    chk("haz_val", s_rv0, 1'b1);
    chk("haz_dat", s_rd0, 32'h12345678);

    // Read routing with both readers saturating
    wr0_req = 1; wr0_adr = 1; wr0_dat = 32'h1;
    cycle();
    wr0_adr = 2; wr0_dat = 32'h2;
    cycle();
    wr0_req = 0; rd0_req = 1; rd0_adr = 1; rd1_req = 1; rd1_adr = 2;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("route_onehot", s_rv0 && s_rv1, 1'b0);
      if (i >= 2) chk("route_nogap", s_rv0 || s_rv1, 1'b1);
      if (s_rg0) rd0_adr = (rd0_adr == 5'd1) ? 5'd2 : 5'd1;
      if (s_rg1) rd1_adr = (rd1_adr == 5'd1) ? 5'd2 : 5'd1;
    end
    rd0_req = 0; rd1_req = 0;
    repeat (2) cycle();

    // Reset while a read is in flight
    rd1_req = 1; rd1_adr = 5;
    cycle();
    chk("mid_rd1_gnt", s_rg1, 1'b1);
    rd1_req = 0; rstn = 0;
    cycle();
    rstn = 1;
    cycle();
    chk("mid_no_val", s_rv1, 1'b0);
    cycle();
    chk("mid_no_val2", s_rv1, 1'b0);

    // Randomized traffic with occasional resets and withdrawals
    for (int i = 0; i < 3000; i++) begin
      if (!wr0_req || s_wg0) begin
        wr0_req = ($urandom_range(0, 3) != 0); wr0_adr = 5'($urandom_range(0, 7));
        wr0_ena = 4'($urandom_range(0, 15)); wr0_dat = $urandom;
      end else if ($urandom_range(0, 19) == 0) wr0_req = 0;
      if (!wr1_req || s_wg1) begin
        wr1_req = ($urandom_range(0, 3) != 0); wr1_adr = 5'($urandom_range(0, 7));
        wr1_ena = 4'($urandom_range(0, 15)); wr1_dat = $urandom;
      end else if ($urandom_range(0, 19) == 0) wr1_req = 0;
      if (!rd0_req || s_rg0) begin
        rd0_req = ($urandom_range(0, 3) != 0); rd0_adr = 5'($urandom_range(0, 7));
      end else if ($urandom_range(0, 19) == 0) rd0_req = 0;
      if (!rd1_req || s_rg1) begin
        rd1_req = ($urandom_range(0, 3) != 0); rd1_adr = 5'($urandom_range(0, 7));
      end else if ($urandom_range(0, 19) == 0) rd1_req = 0;
      rstn = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
